// File: rtl/windowed_covariance.sv
// Sliding-window population covariance over N_STOCKS signed Q-format channels.
// Running sums are updated per accepted sample; the matrix appears two cycles later.

module windowed_cov_pair #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int LOG2W = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    upd,
   input  logic                    ld_e,
   input  logic                    ld_c,
   input  logic signed [WIDTH-1:0] x_i,
   input  logic signed [WIDTH-1:0] x_j,
   input  logic signed [WIDTH-1:0] old_i,
   input  logic signed [WIDTH-1:0] old_j,
   input  logic signed [WIDTH-1:0] m_i,
   input  logic signed [WIDTH-1:0] m_j,
   output logic        [WIDTH-1:0] cov
);
   localparam int XW = 2*WIDTH;
   localparam int PW = 2*WIDTH + LOG2W;
   localparam int CW = PW + 1;
   localparam logic signed [CW-1:0] SAT_HI = {{(CW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [CW-1:0] SAT_LO = {{(CW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [XW-1:0] prod_new, prod_old, mm, e_q;
   logic signed [PW-1:0] p_q;
   logic signed [CW-1:0] c_full, c_shr;
   logic        [WIDTH-1:0] sat;

   assign prod_new = XW'(x_i) * XW'(x_j);
   assign prod_old = XW'(old_i) * XW'(old_j);
   assign mm       = XW'(m_i) * XW'(m_j);
   assign c_full   = CW'(e_q) - CW'(mm);
   assign c_shr    = c_full >>> FRAC;

   always_comb begin
      sat = WIDTH'(c_shr);
      if (c_shr > SAT_HI)
         sat = {1'b0, {(WIDTH-1){1'b1}}};
      else if (c_shr < SAT_LO)
         sat = {1'b1, {(WIDTH-1){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q <= '0;
         e_q <= '0;
         cov <= '0;
      end else begin
         if (clr)
            p_q <= '0;
         else if (upd)
            p_q <= p_q + PW'(prod_new) - PW'(prod_old);
         if (ld_e)
            e_q <= XW'(p_q >>> LOG2W);
         if (ld_c)
            cov <= sat;
      end
   end
endmodule

module windowed_covariance #(
   parameter int N_STOCKS = 2,
   parameter int WIDTH    = 16,
   parameter int FRAC     = 8,
   parameter int WINDOW   = 8,
   localparam int LOG2W   = $clog2(WINDOW)
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          valid_in,
   input  logic [N_STOCKS-1:0][WIDTH-1:0]                x_in,
   input  logic                                          clr,
   output logic                                          valid_out,
   output logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]  cov_out,
   output logic [LOG2W:0]                                fill_count
);
   localparam int SW     = WIDTH + LOG2W;
   localparam int NT     = N_STOCKS*(N_STOCKS+1)/2;
   localparam int STAGES = 2;
   localparam logic [LOG2W:0] FULL_CNT = (LOG2W+1)'(WINDOW);
   localparam logic [LOG2W:0] LAST_CNT = (LOG2W+1)'(WINDOW-1);

   // Upper-triangle index of (a,b) with a<=b, row-major.
   function automatic int tri_idx(int a, int b, int n);
      return a*n - (a*(a-1))/2 + (b-a);
   endfunction

   logic [N_STOCKS-1:0][WIDTH-1:0] buf_mem [WINDOW];
   logic [N_STOCKS-1:0][WIDTH-1:0] old_v;
   logic [LOG2W-1:0]               wr_ptr;
   logic                           full, accept;
   logic [STAGES:0]                vld_pipe;
   logic [NT-1:0][WIDTH-1:0]       cov_tri;

   logic signed [WIDTH-1:0] x_s   [N_STOCKS];
   logic signed [WIDTH-1:0] old_s [N_STOCKS];
   logic signed [WIDTH-1:0] m_q   [N_STOCKS];
   logic signed [SW-1:0]    s_q   [N_STOCKS];

   assign full      = (fill_count == FULL_CNT);
   assign accept    = valid_in && !clr;
   assign old_v     = full ? buf_mem[wr_ptr] : '0;
   assign valid_out = vld_pipe[STAGES];

   for (genvar i = 0; i < N_STOCKS; i++) begin : g_lane
      assign x_s[i]   = $signed(x_in[i]);
      assign old_s[i] = $signed(old_v[i]);
   end

   // Sample storage needs no reset: stale entries are masked until the window refills.
   always_ff @(posedge clk) begin
      if (accept && !rst)
         buf_mem[wr_ptr] <= x_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         fill_count <= '0;
         vld_pipe   <= '0;
         for (int i = 0; i < N_STOCKS; i++) begin
            s_q[i] <= '0;
            m_q[i] <= '0;
         end
      end else begin
         vld_pipe[0]        <= accept && (full || fill_count == LAST_CNT);
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         if (clr) begin
            wr_ptr     <= '0;
            fill_count <= '0;
         end else if (valid_in) begin
            wr_ptr <= wr_ptr + LOG2W'(1);
            if (!full)
               fill_count <= fill_count + (LOG2W+1)'(1);
         end
         for (int i = 0; i < N_STOCKS; i++) begin
            if (clr)
               s_q[i] <= '0;
            else if (valid_in)
               s_q[i] <= s_q[i] + SW'(x_s[i]) - SW'(old_s[i]);
            if (vld_pipe[0])
               m_q[i] <= WIDTH'(s_q[i] >>> LOG2W);
         end
      end
   end

   for (genvar i = 0; i < N_STOCKS; i++) begin : g_row
      for (genvar j = i; j < N_STOCKS; j++) begin : g_col
         windowed_cov_pair #(.WIDTH(WIDTH), .FRAC(FRAC), .LOG2W(LOG2W)) u_pair (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .upd   (accept),
            .ld_e  (vld_pipe[0]),
            .ld_c  (vld_pipe[1]),
            .x_i   (x_s[i]),
            .x_j   (x_s[j]),
            .old_i (old_s[i]),
            .old_j (old_s[j]),
            .m_i   (m_q[i]),
            .m_j   (m_q[j]),
            .cov   (cov_tri[tri_idx(i, j, N_STOCKS)])
         );
      end
   end

   // Lower triangle mirrors the computed upper triangle.
   for (genvar i = 0; i < N_STOCKS; i++) begin : g_out_r
      for (genvar j = 0; j < N_STOCKS; j++) begin : g_out_c
         localparam int A = (i < j) ? i : j;
         localparam int B = (i < j) ? j : i;
         assign cov_out[i][j] = cov_tri[tri_idx(A, B, N_STOCKS)];
      end
   end
endmodule

// File: tb/tb_windowed_covariance.sv
// Bench for windowed_covariance: window-level reference model plus directed literal checks.

module tb_windowed_covariance;
   localparam int N = 2, W = 16, F = 8, WIN = 4, L = 2;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic                         valid_in = 1'b0;
   logic                         clr = 1'b0;
   logic [N-1:0][W-1:0]          x_in = '0;
   logic                         valid_out;
   logic [N-1:0][N-1:0][W-1:0]   cov_out;
   logic [L:0]                   fill_count;

   windowed_covariance #(.N_STOCKS(N), .WIDTH(W), .FRAC(F), .WINDOW(WIN)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .x_in       (x_in),
      .clr        (clr),
      .valid_out  (valid_out),
      .cov_out    (cov_out),
      .fill_count (fill_count)
   );

   always #5 clk = ~clk;

   typedef int vec_t [N];
   typedef int mat_t [N][N];
   typedef struct { int due; mat_t cov; } res_t;

   int   tests = 0, fails = 0, cyc = 0;
   vec_t win[$];
   res_t pend[$];
   mat_t held = '{default: 0};
   int   mfill = 0;
   bit   exp_v;

   task automatic check(string name, longint act, longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Covariance straight from the samples currently in the window.
   task automatic model_cov(output mat_t c);
      longint s [N];
      longint p, mi, mj, e, cc;
      for (int i = 0; i < N; i++) begin
         s[i] = 0;
         foreach (win[k]) s[i] += win[k][i];
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            p = 0;
            foreach (win[k]) p += longint'(win[k][i]) * longint'(win[k][j]);
            mi = s[i] >>> L;
            mj = s[j] >>> L;
            e  = p >>> L;
            cc = (e - mi*mj) >>> F;
            if (cc > 32767) cc = 32767;
            if (cc < -32768) cc = -32768;
            c[i][j] = int'(cc);
         end
   endtask

   // Model update on each edge, comparison on the following falling edge.
   initial begin
      vec_t v;
      res_t r;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            win.delete();
            pend.delete();
            mfill = 0;
            held  = '{default: 0};
         end else if (clr) begin
            win.delete();
            mfill = 0;
         end else if (valid_in) begin
            for (int i = 0; i < N; i++) v[i] = $signed(x_in[i]);
            win.push_back(v);
            if (win.size() > WIN) void'(win.pop_front());
            mfill = win.size();
            if (win.size() == WIN) begin
               r.due = cyc + 2;
               model_cov(r.cov);
               pend.push_back(r);
            end
         end
         @(negedge clk);
         exp_v = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_v = 1'b1;
            held  = pend[0].cov;
            void'(pend.pop_front());
         end
         check("valid_out", valid_out, exp_v);
         check("fill_count", fill_count, mfill);
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               check($sformatf("cov_out[%0d][%0d]", i, j), $signed(cov_out[i][j]), held[i][j]);
      end
   end

   task automatic drv(bit r, bit c, bit v, int a, int b);
      @(negedge clk);
      rst      = r;
      clr      = c;
      valid_in = v;
      x_in[0]  = W'(a);
      x_in[1]  = W'(b);
   endtask

   task automatic idle(int n);
      repeat (n) drv(0, 0, 0, 0, 0);
   endtask

   function automatic int rnd_sample();
      if ($urandom_range(0, 1) == 1)
         return int'($urandom_range(0, 65535)) - 32768;
      return int'($urandom_range(0, 2047)) - 1024;
   endfunction

   initial begin
      int a, b, r;
      drv(1, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0);
      #2 check("reset valid_out", valid_out, 0);
      check("reset fill_count", fill_count, 0);
      check("reset cov00", cov_out[0][0], 0);

      // Warm-up: x0 = 0,1,2,3 ; x1 = 3.0
      drv(0, 0, 1, 0, 768);
      drv(0, 0, 1, 256, 768);  #2 check("warm fill1", fill_count, 1);
      drv(0, 0, 1, 512, 768);  #2 check("warm fill2", fill_count, 2);
      drv(0, 0, 1, 768, 768);  #2 check("warm fill3", fill_count, 3);
      idle(1); #2 check("warm fill4", fill_count, 4);
      check("warm no pulse k", valid_out, 0);
      idle(1); #2 check("warm no pulse k+1", valid_out, 0);
      idle(1); #2 check("warm pulse", valid_out, 1);
      check("warm cov00", $signed(cov_out[0][0]), 320);
      check("warm cov01", $signed(cov_out[0][1]), 0);
      check("warm cov11", $signed(cov_out[1][1]), 0);
      check("model pin warm cov00", held[0][0], 320);

      // Slide one sample
      drv(0, 0, 1, 1024, 768);
      idle(3); #2 check("slide pulse", valid_out, 1);
      check("slide cov00", $signed(cov_out[0][0]), 320);
      check("slide fill", fill_count, 4);

      // Anti-correlated channels
      drv(1, 0, 0, 0, 0);
      drv(0, 0, 1, 256, -256);
      drv(0, 0, 1, -256, 256);
      drv(0, 0, 1, 256, -256);
      drv(0, 0, 1, -256, 256);
      idle(3); #2 check("neg pulse", valid_out, 1);
      check("neg cov00", $signed(cov_out[0][0]), 256);
      check("neg cov11", $signed(cov_out[1][1]), 256);
      check("neg cov01", $signed(cov_out[0][1]), -256);
      check("neg cov10", $signed(cov_out[1][0]), -256);
      check("model pin neg cov01", held[0][1], -256);

      // Saturation
      drv(1, 0, 0, 0, 0);
      drv(0, 0, 1, 32512, 0);
      drv(0, 0, 1, -32768, 0);
      drv(0, 0, 1, 32512, 0);
      drv(0, 0, 1, -32768, 0);
      idle(3); #2 check("sat cov00", $signed(cov_out[0][0]), 32767);
      check("sat cov01", $signed(cov_out[0][1]), 0);
      check("sat cov11", $signed(cov_out[1][1]), 0);
      check("model pin sat cov00", held[0][0], 32767);

      // Gaps and clear
      drv(1, 0, 0, 0, 0);
      drv(0, 0, 1, 100, 200);
      idle(2);
      drv(0, 0, 1, 300, -50);
      drv(0, 1, 1, 999, 999);
      idle(1); #2 check("clr fill", fill_count, 0);
      check("clr valid_out", valid_out, 0);
      drv(0, 0, 1, 10, 20);
      drv(0, 0, 1, -30, 40);
      idle(1);
      drv(0, 0, 1, 50, -60);
      idle(2);
      drv(0, 0, 1, 70, 80);
      idle(3); #2 check("post-clr pulse", valid_out, 1);

      // Reset right after a full-window sample
      drv(0, 0, 1, 500, 600);
      drv(1, 0, 0, 0, 0);
      idle(1); #2 check("rst mid valid", valid_out, 0);
      check("rst mid cov00", cov_out[0][0], 0);
      check("rst mid fill", fill_count, 0);
      idle(1); #2 check("rst mid dropped", valid_out, 0);

      // Randomized traffic
      repeat (400) begin
         r = int'($urandom_range(0, 99));
         a = rnd_sample();
         b = rnd_sample();
         drv(r < 1, (r >= 1 && r < 4), (r >= 25), a, b);
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/windowed_covariance.md
# windowed_covariance

Streaming sliding-window covariance engine for N_STOCKS price/return channels in signed Q fixed point. It replaces the fixed-length covariance accumulator with a parametrised window of the most recent WINDOW accepted samples. It also adds warm-up gating, a synchronous window clear, an occupancy output and saturating output conversion. It sits between the per-tick return calculator and the portfolio optimiser, emitting one full symmetric N_STOCKS×N_STOCKS matrix per accepted sample once the window is full.

## Interface
- N_STOCKS, 2, number of input channels (≥1)
- WIDTH, 16, bit width of every input sample and output element (signed)
- FRAC, 8, fractional bits of inputs and outputs (Q(WIDTH-FRAC).FRAC)
- WINDOW, 8, window length in samples; power of two, ≥2; LOG2W = log2(WINDOW)
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  x_in carries a new sample this cycle; always accepted (no backpressure)
- x_in  in  [N_STOCKS-1:0][WIDTH-1:0]  signed sample vector
- clr  in  1  synchronous window clear (empties window, keeps pipeline timing)
- valid_out  out  1  cov_out holds a new matrix this cycle (single-cycle pulse per result)
- cov_out  out  [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]  signed covariance matrix, Q.FRAC
- fill_count  out  LOG2W+1  samples currently in window (0..WINDOW)

## Operation
- Storage: circular buffer of WINDOW sample vectors, write pointer wraps modulo WINDOW.
- Running sums: S_i (WIDTH+LOG2W bits, signed), P_ij for i≤j (2·WIDTH+LOG2W bits, signed); lower triangle mirrored, never computed separately.
- On accepted sample x: old = buffer[wr_ptr] if fill_count==WINDOW else 0; S_i += x_i − old_i; P_ij += x_i·x_j − old_i·old_j; buffer[wr_ptr] = x; wr_ptr++; fill_count saturates at WINDOW.
- Result math (population covariance, arithmetic shifts = floor):
  - M_i = S_i >>> LOG2W
  - E_ij = P_ij >>> LOG2W
  - C_ij = E_ij − M_i·M_j, computed in 2·WIDTH+LOG2W+1 bits
  - cov_ij = C_ij >>> FRAC, saturated to [−2^(WIDTH-1), 2^(WIDTH-1)−1]; cov_ji = cov_ij
- Warm-up: a result is launched only for samples that leave fill_count==WINDOW after update; earlier samples update sums silently.
- clr: zeroes S, P, fill_count, wr_ptr (buffer contents need not be cleared; gated by fill_count). clr with valid_in in same cycle: clr wins, sample dropped. In-flight pipeline results still emerge.
- No valid_in: sums, pointer, cov_out hold; valid_out low.
- rst: zeroes sums, fill_count, wr_ptr, pipeline valids, cov_out; overrides clr and valid_in; a reset mid-pipeline drops in-flight results.

## Timing
- Reset values: valid_out=0, cov_out all 0, fill_count=0.
- Edge k (valid_in=1): sums/buffer/fill_count updated; fill_count visible after edge k.
- Edge k+1: M_i, E_ij registered. Edge k+2: cov_out, valid_out registered → latency 2 cycles, throughput 1 sample/cycle.
- Back-to-back valid_in yields back-to-back valid_out pulses once full.
- cov_out holds last result between valid_out pulses.

## Test plan
All with N_STOCKS=2, WIDTH=16, FRAC=8, WINDOW=4.
- Warm-up: x0=0,1,2,3 (0,256,512,768), x1=3.0 (768) on 4 consecutive cycles → valid_out low for first 3; fill_count 1,2,3,4; single pulse 2 cycles after 4th edge with cov=[[320,0],[0,0]].
- Slide: continue with x0=4.0 (1024), x1=768 → next pulse cov00=320 (window 1..4), others 0; fill_count stays 4.
- Negative/cross term: after rst, x0=+1,−1,+1,−1 (±256), x1=−1,+1,−1,+1 → cov00=256, cov11=256, cov01=cov10=−256 (0xFF00).
- Saturation: x0=32512,−32768,32512,−32768, x1=0 → cov00=32767, cov01=cov10=0, cov11=0.
- Gaps/clear: sample stream with valid_in idle cycles → outputs hold, no valid_out; assert clr with valid_in after 2 samples → sample dropped, fill_count=0, no valid_out until 4 further samples.
- Reset mid-pipeline: rst on edge after a full-window sample → no valid_out follows, cov_out=0, fill_count=0.
